// File: rtl/video_sync_gen.sv
// video_sync_gen: raster timing generator for a framebuffer stage.
// The stage-0 counters issue a registered pixel fetch request (o_req, o_req_x,
// o_req_y). The matching o_de/o_hsync/o_vsync/o_frame_start come out 2 clocks
// after that request, which gives the fetch a fixed 2-cycle latency.
// Dropping i_ena clears the counters and every pipeline stage at the next edge.
// Optional feature: define VIDEO_SYNC_GEN_FRAME_CNT_EN to add the 16-bit
// o_frame_cnt output, which counts o_frame_start pulses.
module video_sync_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20
) (
   input  logic        i_nrst,
   input  logic        i_clk,
   input  logic        i_ena,
   output logic        o_req,
   output logic [11:0] o_req_x,
   output logic [10:0] o_req_y,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_frame_start
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
   ,
   output logic [15:0] o_frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] LP_H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] LP_HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] LP_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] LP_H_LAST = 12'(H_TOTAL - 1);
   localparam logic [10:0] LP_V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] LP_VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] LP_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] LP_V_LAST = 11'(V_TOTAL - 1);

   logic [11:0] r_hcnt;
   logic [10:0] r_vcnt;

   logic w_h_wrap, w_v_wrap;
   logic w_act0, w_hs0, w_vs0, w_fs0;

   // stage 1 (the request register) carries sync/start alongside o_req
   logic r_s1_hs, r_s1_vs, r_s1_fs;
   logic r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs;
   logic r_s3_de, r_s3_hs, r_s3_vs, r_s3_fs;
   logic        r_req;
   logic [11:0] r_req_x;
   logic [10:0] r_req_y;

   assign w_h_wrap = (r_hcnt == LP_H_LAST);
   assign w_v_wrap = (r_vcnt == LP_V_LAST);
   assign w_act0   = (r_hcnt < LP_H_ACT) && (r_vcnt < LP_V_ACT);
   assign w_hs0    = (r_hcnt >= LP_HS_BEG) && (r_hcnt < LP_HS_END);
   // vcnt only moves on an hcnt wrap, so vsync spans whole lines
   assign w_vs0    = (r_vcnt >= LP_VS_BEG) && (r_vcnt < LP_VS_END);
   assign w_fs0    = (r_hcnt == 12'd0) && (r_vcnt == 11'd0);

   // Raster counters; a low i_ena wins over any wrap and parks them at 0
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_hcnt <= 12'd0;
         r_vcnt <= 11'd0;
      end else if (!i_ena) begin
         r_hcnt <= 12'd0;
         r_vcnt <= 11'd0;
      end else if (w_h_wrap) begin
         r_hcnt <= 12'd0;
         r_vcnt <= w_v_wrap ? 11'd0 : r_vcnt + 11'd1;
      end else begin
         r_hcnt <= r_hcnt + 12'd1;
      end
   end

   // Request register plus two delay stages; a low i_ena flushes everything at once
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_req   <= 1'b0;
         r_req_x <= 12'd0;
         r_req_y <= 11'd0;
         r_s1_hs <= 1'b0; r_s1_vs <= 1'b0; r_s1_fs <= 1'b0;
         r_s2_de <= 1'b0; r_s2_hs <= 1'b0; r_s2_vs <= 1'b0; r_s2_fs <= 1'b0;
         r_s3_de <= 1'b0; r_s3_hs <= 1'b0; r_s3_vs <= 1'b0; r_s3_fs <= 1'b0;
      end else if (!i_ena) begin
         r_req   <= 1'b0;
         r_req_x <= 12'd0;
         r_req_y <= 11'd0;
         r_s1_hs <= 1'b0; r_s1_vs <= 1'b0; r_s1_fs <= 1'b0;
         r_s2_de <= 1'b0; r_s2_hs <= 1'b0; r_s2_vs <= 1'b0; r_s2_fs <= 1'b0;
         r_s3_de <= 1'b0; r_s3_hs <= 1'b0; r_s3_vs <= 1'b0; r_s3_fs <= 1'b0;
      end else begin
         r_req   <= w_act0;
         r_req_x <= w_act0 ? r_hcnt : 12'd0;
         r_req_y <= w_act0 ? r_vcnt : 11'd0;
         r_s1_hs <= w_hs0;
         r_s1_vs <= w_vs0;
         r_s1_fs <= w_fs0;
         r_s2_de <= r_req;
         r_s2_hs <= r_s1_hs;
         r_s2_vs <= r_s1_vs;
         r_s2_fs <= r_s1_fs;
         r_s3_de <= r_s2_de;
         r_s3_hs <= r_s2_hs;
         r_s3_vs <= r_s2_vs;
         r_s3_fs <= r_s2_fs;
      end
   end

   assign o_req         = r_req;
   assign o_req_x       = r_req_x;
   assign o_req_y       = r_req_y;
   assign o_de          = r_s3_de;
   assign o_hsync       = r_s3_hs;
   assign o_vsync       = r_s3_vs;
   assign o_frame_start = r_s3_fs;

`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   // Count frame-start pulses; the 16-bit add wraps 0xFFFF to 0 on its own
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_frame_cnt <= 16'd0;
      end else if (!i_ena) begin
         r_frame_cnt <= 16'd0;
      end else if (r_s3_fs) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: directed bench for video_sync_gen with a tiny raster
// (H=8/2/2/2 -> 14 clocks per line, V=4/1/1/1 -> 7 lines, 98 clocks per frame).
// Expected values come from the raster arithmetic: k clocks after (re)start,
// o_req shows raster position k-1 and o_de/o_hsync/o_vsync/o_frame_start show k-3.
// Define VIDEO_SYNC_GEN_FRAME_CNT_EN to also exercise o_frame_cnt.
module tb_video_sync_gen;

   logic        i_nrst;
   logic        i_clk;
   logic        i_ena;
   logic        o_req;
   logic [11:0] o_req_x;
   logic [10:0] o_req_y;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_de;
   logic        o_frame_start;
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
   logic [15:0] o_frame_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int fs_cnt, req_cnt, hs_cnt, vs_cnt;

   video_sync_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut (
      .i_nrst        (i_nrst),
      .i_clk         (i_clk),
      .i_ena         (i_ena),
      .o_req         (o_req),
      .o_req_x       (o_req_x),
      .o_req_y       (o_req_y),
      .o_hsync       (o_hsync),
      .o_vsync       (o_vsync),
      .o_de          (o_de),
      .o_frame_start (o_frame_start)
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
      ,
      .o_frame_cnt   (o_frame_cnt)
`endif
   );

   // free-running pixel clock, 10 time units per period
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one clock and land 2 units after the rising edge
   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"}, o_req, 0);
      chk({tag, "_x"},   o_req_x, 0);
      chk({tag, "_y"},   o_req_y, 0);
      chk({tag, "_de"},  o_de, 0);
      chk({tag, "_hs"},  o_hsync, 0);
      chk({tag, "_vs"},  o_vsync, 0);
      chk({tag, "_fs"},  o_frame_start, 0);
   endtask

   // expected outputs k clocks after a restart from hcnt=0, vcnt=0
   task automatic chk_all(input int k);
      int pr, pd, hr, vr, hd, vd;
      logic e_req, e_de, e_hs, e_vs, e_fs;
      logic [31:0] e_x, e_y;
      pr = k - 1;
      pd = k - 3;
      hr = pr % 14; vr = (pr / 14) % 7;
      hd = pd % 14; vd = (pd / 14) % 7;
      e_req = (pr >= 0) && (hr < 8) && (vr < 4);
      e_x   = e_req ? 32'(hr) : 32'd0;
      e_y   = e_req ? 32'(vr) : 32'd0;
      e_de  = (pd >= 0) && (hd < 8) && (vd < 4);
      e_hs  = (pd >= 0) && (hd >= 10) && (hd < 12);
      e_vs  = (pd >= 0) && (vd == 5);
      e_fs  = (pd >= 0) && (pd % 98 == 0);
      chk("req", o_req, e_req);
      chk("req_x", o_req_x, e_x);
      chk("req_y", o_req_y, e_y);
      chk("de", o_de, e_de);
      chk("hsync", o_hsync, e_hs);
      chk("vsync", o_vsync, e_vs);
      chk("frame_start", o_frame_start, e_fs);
   endtask

   initial begin
      // reset state with enable low
      i_nrst = 1'b0;
      i_ena  = 1'b0;
      #12;
      chk_zero("reset");
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
      chk("reset_fcnt", o_frame_cnt, 0);
`endif

      // release reset away from the edge with enable high; run two full frames
      @(negedge i_clk);
      i_nrst = 1'b1;
      i_ena  = 1'b1;
      fs_cnt = 0; req_cnt = 0; hs_cnt = 0; vs_cnt = 0;
      for (int k = 1; k <= 196; k++) begin
         tick();
         chk_all(k);
         if (k == 1) begin
            chk("first_req", o_req, 1);
            chk("first_x", o_req_x, 0);
            chk("first_y", o_req_y, 0);
         end
         if (k == 32) begin
            chk("lat_req", o_req, 1);
            chk("lat_x", o_req_x, 3);
            chk("lat_y", o_req_y, 2);
         end
         if (k == 34) chk("lat_de", o_de, 1);
         if (k == 3)  chk("fs_first", o_frame_start, 1);
         if (k == 101) chk("fs_second", o_frame_start, 1);
         fs_cnt  += int'(o_frame_start);
         req_cnt += int'(o_req);
         hs_cnt  += int'(o_hsync);
         vs_cnt  += int'(o_vsync);
      end
      chk("fs_count", fs_cnt, 2);
      chk("req_count", req_cnt, 64);
      chk("hs_count", hs_cnt, 28);
      chk("vs_count", vs_cnt, 28);
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
      chk("fcnt_two", o_frame_cnt, 2);
`endif

      // mid-frame disable at hcnt=5, vcnt=1
      i_ena = 1'b0;
      tick();
      chk_zero("sync_off");
      i_ena = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         tick();
         chk_all(k);
      end
      chk("pre_off_req", o_req, 1);
      chk("pre_off_de", o_de, 1);
      i_ena = 1'b0;
      tick();
      chk_zero("off");
`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
      chk("off_fcnt", o_frame_cnt, 0);
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_zero("off_hold");
      end
      i_ena = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk_all(k);
         if (k == 1) begin
            chk("reen_req", o_req, 1);
            chk("reen_x", o_req_x, 0);
            chk("reen_y", o_req_y, 0);
         end
      end

      // asynchronous reset while o_de is high, asserted between edges
      chk("pre_rst_de", o_de, 1);
      #2;
      i_nrst = 1'b0;
      #1;
      chk_zero("async_rst");
      tick();
      chk_zero("rst_hold");
      i_nrst = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         chk_all(k);
         if (k == 1) begin
            chk("post_rst_x", o_req_x, 0);
            chk("post_rst_y", o_req_y, 0);
            chk("post_rst_req", o_req, 1);
         end
      end

`ifdef VIDEO_SYNC_GEN_FRAME_CNT_EN
      // frame counter: three full frames, then wrap from a forced 0xFFFF
      i_ena = 1'b0;
      tick();
      chk("fcnt_clear", o_frame_cnt, 0);
      i_ena = 1'b1;
      for (int k = 1; k <= 294; k++) begin
         tick();
         chk_all(k);
      end
      chk("fcnt_three", o_frame_cnt, 3);
      force dut.r_frame_cnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      chk("fcnt_forced", o_frame_cnt, 16'hFFFF);
      for (int k = 295; k <= 300; k++) begin
         tick();
         chk_all(k);
      end
      chk("fcnt_wrap", o_frame_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/video_sync_gen.md
VIDEO_SYNC_GEN -- requirements
Module: video_sync_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 40, hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 220, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 720, visible lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 5, 5 and 20, vertical porches and sync in lines.
REQ-007 SHALL have port i_nrst, input, 1 bit, reset, asynchronous and active-low.
REQ-008 SHALL have port i_clk, input, 1 bit, pixel clock, the only clock.
REQ-009 SHALL have port i_ena, input, 1 bit, timing enable.
REQ-010 SHALL have port o_req, output, 1 bit, pixel fetch request to the framebuffer stage.
REQ-011 SHALL have port o_req_x, output, 12 bits, column of the requested pixel.
REQ-012 SHALL have port o_req_y, output, 11 bits, row of the requested pixel.
REQ-013 SHALL have ports o_hsync, o_vsync and o_de, outputs, 1 bit each, active-high sync and data-enable for the framebuffer stage.
REQ-014 SHALL have port o_frame_start, output, 1 bit, one-cycle pulse on the first active pixel of a frame.

Function
REQ-015 SHALL derive H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-016 SHALL run hcnt 0..H_TOTAL-1, incrementing every clock while i_ena=1 and wrapping to 0 after H_TOTAL-1.
REQ-017 SHALL advance vcnt only on an hcnt wrap, running 0..V_TOTAL-1 and wrapping to 0 after V_TOTAL-1.
REQ-018 SHALL define stage-0 active as hcnt<H_ACTIVE and vcnt<V_ACTIVE; o_req equals stage-0 active, registered, with o_req_x=hcnt and o_req_y=vcnt.
REQ-019 SHALL hold o_req_x and o_req_y at 0 when o_req=0.
REQ-020 SHALL assert stage-0 hsync for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-021 SHALL assert stage-0 vsync for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for whole lines only, changing at hcnt=0.
REQ-022 SHALL delay stage-0 active, hsync and vsync by a 2-stage register pipeline to form o_de, o_hsync and o_vsync.
REQ-023 SHALL produce the o_de for each pixel exactly 2 clocks after the o_req for that pixel, which gives the framebuffer fetch a fixed 2-cycle latency.
REQ-024 SHALL pulse o_frame_start together with the o_de of the pixel at hcnt=0, vcnt=0.
REQ-025 SHALL restart counting at hcnt=0 and vcnt=0 when i_ena rises, with the first o_req on the first enabled cycle.
REQ-026 SHALL, when i_ena falls mid-frame, clear the counters, o_req and the whole pipeline at the next edge, so every output reads 0 one clock later and no partial pipeline drain occurs.
REQ-027 SHALL give i_ena=0 priority over counter wrap when both occur in the same cycle.

Reset
REQ-028 SHALL clear hcnt, vcnt, the pipeline and all outputs to 0 immediately while i_nrst=0, independent of i_clk.
REQ-029 SHALL start at hcnt=0, vcnt=0 on the first clock edge after i_nrst is released, if i_ena=1.

Configuration
REQ-030 SHALL, with VIDEO_SYNC_GEN_FRAME_CNT_EN defined, add output o_frame_cnt, 16 bits, which increments on each o_frame_start, wraps at 0xFFFF to 0 and is cleared by reset and by i_ena=0.
REQ-031 SHALL, with VIDEO_SYNC_GEN_FRAME_CNT_EN undefined, omit the o_frame_cnt port and its register entirely.

Verification
REQ-032 SHALL test timing with H=8/2/2/2 and V=4/1/1/1, i_ena=1 held: o_req high 8 of every 14 clocks for 4 of 7 lines, o_hsync high at hcnt 10-11 delayed by 2 clocks, and o_vsync high for line 5 only.
REQ-033 SHALL test latency with the same parameters: o_req with o_req_x=3, o_req_y=2 is followed exactly 2 clocks later by o_de=1, and o_frame_start pulses once per 98 clocks.
REQ-034 SHALL test mid-frame disable: i_ena dropped at hcnt=5, vcnt=1 gives all outputs 0 at the next edge; on re-enable the first o_req has x=0, y=0.
REQ-035 SHALL test asynchronous reset: i_nrst asserted between clock edges while o_de=1 drives outputs to 0 without waiting for a clock edge; after release, the sequence restarts at x=0, y=0.
REQ-036 SHALL test the frame counter with VIDEO_SYNC_GEN_FRAME_CNT_EN defined: after 3 full frames o_frame_cnt=3, and with the counter preloaded to 0xFFFF by force, the next frame gives 0.
